mem_requester: RTL and testbench
================================

# mem_requester

Initiator side of the memory-controller request protocol. It arbitrates between the instruction fetch unit and the load/store buffer (LSB) and drives `status_signal`, `instr_a`, `lsb_addr` and `lsb_din` into `memory_controller`. It holds each request stable until the matching `*_done`, then returns the result to the originator. It also discards fetch results made stale by a pipeline rollback.

## Interface
Parameters: none (encodings come from the shared package).

- `clk_in` in 1: system clock
- `rst_in` in 1: synchronous, active-high reset
- `rdy_in` in 1: global ready; when low, all state holds
- `rollback` in 1: pipeline flush; kills fetch traffic only
- `if_req_valid` in 1: fetch request pending
- `if_req_addr` in 32: fetch address
- `if_req_ready` out 1: request accepted this cycle (combinational)
- `if_resp_valid` out 1: one-cycle pulse, instruction returned
- `if_resp_data` out 32: fetched instruction
- `lsb_req_valid` in 1: LSB request pending
- `lsb_req_wr` in 1: 1 = store, 0 = load
- `lsb_req_addr` in 32: load/store address
- `lsb_req_data` in 32: store data
- `lsb_req_ready` out 1: request accepted this cycle (combinational)
- `lsb_resp_valid` out 1: one-cycle pulse; load data valid, or store complete
- `lsb_resp_data` out 32: load data (0 for stores)
- `status_signal` out 2: 11 fetch, 10 load, 01 store, 00 idle
- `instr_a` out 32: fetch address to controller
- `instr_d` in 32: fetched word from controller
- `instr_done` in 1: fetch complete (one-cycle pulse)
- `lsb_addr` out 32: load/store address to controller
- `lsb_din` out 32: store data to controller
- `lsb_dout` in 32: load data from controller
- `lsb_done` in 1: load/store complete (one-cycle pulse)

## Operation
- States: IDLE, FETCH, LOAD, STORE. `status_signal` is decoded from the registered state: IDLE→00, FETCH→11, LOAD→10, STORE→01.
- IDLE arbitration, evaluated only while `rdy_in`=1:
  - LSB has priority.
  - Exception: if the last granted transaction was LSB and `if_req_valid`=1 (with `rollback`=0), fetch wins. When both are pending, grants therefore alternate.
  - At most one `*_req_ready` is high per cycle.
  - `if_req_ready` is forced low while `rollback`=1.
- On accept, the request is latched into `instr_a` or `lsb_addr`/`lsb_din`. Next state is FETCH, LOAD or STORE according to `lsb_req_wr`.
- In FETCH/LOAD/STORE, all outputs to the controller stay constant until the matching done is sampled. Then:
  - state → IDLE;
  - response data is registered;
  - the response-valid flag is set for exactly one cycle.
- A done for the non-matching channel is ignored.
- Store: `lsb_resp_valid` pulses with `lsb_resp_data`=0.
- Rollback:
  - Sampled in FETCH, or in the same cycle as `instr_done`: sets a `kill` flag, and no `if_resp_valid` is produced for that fetch.
  - `kill` clears on return to IDLE.
  - `if_resp_valid` = registered flag AND NOT `rollback`.
  - LOAD and STORE are never affected by rollback.
- `rdy_in`=0: every register holds, done inputs are not sampled, and the `*_req_ready` outputs are 0.

## Timing
- Reset value of every output: 0, with `status_signal`=00. State = IDLE, `kill`=0, last-grant = fetch (so LSB wins first).
- Reset mid-transaction: the in-flight request is dropped and no response is issued.
- Accept in cycle T → `status_signal`≠00 from T+1.
- Done sampled in cycle D → status 00 and `*_resp_valid`=1 in D+1.
- Earliest next accept is D+1, so status shows 00 for at least one cycle between transactions.
- Minimum turnaround from request to response is controller latency + 2 cycles.
- Back-to-back requests: never more than one transaction outstanding.

## Structure
- Package `mem_req_pkg`:
  - status encodings `ST_IDLE`=2'b00, `ST_STORE`=2'b01, `ST_LOAD`=2'b10, `ST_FETCH`=2'b11;
  - the state typedef.
- Single module with no sub-modules. Arbitration and the FSM live in one always block, plus a combinational ready/valid gate.

## Test plan
- Fetch only: `if_req_addr`=0x100 accepted at T → status=11 and `instr_a`=0x100 at T+1. `instr_done` with `instr_d`=0x00A00093 → `if_resp_valid` pulse carrying 0x00A00093 one cycle later.
- Both pending continuously, starting after reset: grant order is load, fetch, load, fetch. Status shows 00 for ≥1 cycle between grants.
- Store of 0xDEADBEEF to 0x30000: status=01 and `lsb_din`=0xDEADBEEF held until `lsb_done` → `lsb_resp_valid`=1, `lsb_resp_data`=0.
- `rollback` pulsed mid-FETCH → state returns to IDLE on `instr_done`, but no `if_resp_valid` is ever seen. A subsequent fetch of 0x200 completes normally.
- `rdy_in` low for 5 cycles during LOAD with `lsb_done` toggling → outputs frozen and the done is ignored. The load completes only on a done sampled after `rdy_in` rises.
- `rst_in` asserted mid-STORE → next cycle all outputs are 0 and status is 00, and no `lsb_resp_valid` appears.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared encodings for the memory-controller request protocol.
// status_signal values seen by memory_controller, and the requester FSM
// state type whose encoding matches those status values directly.
package mem_req_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_STORE = 2'b01;
  localparam logic [1:0] ST_LOAD  = 2'b10;
  localparam logic [1:0] ST_FETCH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_STORE = ST_STORE,
    S_LOAD  = ST_LOAD,
    S_FETCH = ST_FETCH
  } state_e;

endpackage

// File: rtl/mem_requester.sv
// mem_requester: initiator side of the memory-controller request protocol.
// Arbitrates between instruction fetch and the load/store buffer, holds one
// request at a time stable towards memory_controller until its done pulse,
// and returns the result to the originator as a one-cycle response pulse.
// Fetch results overlapped by a rollback are discarded.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global hold), rollback
//   if_req_*  / if_resp_*   : fetch unit request/response
//   lsb_req_* / lsb_resp_*  : load/store buffer request/response
//   status_signal, instr_a, lsb_addr, lsb_din      : to memory_controller
//   instr_d, instr_done, lsb_dout, lsb_done         : from memory_controller
module mem_requester (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rollback,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        lsb_req_valid,
  input  logic        lsb_req_wr,
  input  logic [31:0] lsb_req_addr,
  input  logic [31:0] lsb_req_data,
  output logic        lsb_req_ready,
  output logic        lsb_resp_valid,
  output logic [31:0] lsb_resp_data,
  output logic [1:0]  status_signal,
  output logic [31:0] instr_a,
  input  logic [31:0] instr_d,
  input  logic        instr_done,
  output logic [31:0] lsb_addr,
  output logic [31:0] lsb_din,
  input  logic [31:0] lsb_dout,
  input  logic        lsb_done
);
  import mem_req_pkg::*;

  state_e      state_q;
  logic        last_lsb_q;     // last grant went to the LSB
  logic        kill_q;         // current fetch was overlapped by a rollback
  logic        if_resp_q;
  logic        lsb_resp_q;
  logic [31:0] instr_a_q;
  logic [31:0] lsb_addr_q;
  logic [31:0] lsb_din_q;
  logic [31:0] if_resp_data_q;
  logic [31:0] lsb_resp_data_q;

  logic        lsb_win;
  logic        if_win;
  logic        idle_ok;

  // LSB normally wins; a pending, non-flushed fetch wins right after an LSB
  // grant, so continuous contention alternates.
  always_comb begin
    lsb_win       = lsb_req_valid && !(last_lsb_q && if_req_valid && !rollback);
    if_win        = if_req_valid && !rollback && !lsb_win;
    idle_ok       = rdy_in && !rst_in && (state_q == S_IDLE);
    lsb_req_ready = idle_ok && lsb_win;
    if_req_ready  = idle_ok && if_win;
    // A rollback in the response cycle still suppresses the fetch result.
    if_resp_valid = if_resp_q && !rollback;
  end

  assign lsb_resp_valid = lsb_resp_q;
  assign if_resp_data   = if_resp_data_q;
  assign lsb_resp_data  = lsb_resp_data_q;
  assign status_signal  = state_q;
  assign instr_a        = instr_a_q;
  assign lsb_addr       = lsb_addr_q;
  assign lsb_din        = lsb_din_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= S_IDLE;
      last_lsb_q      <= 1'b0;
      kill_q          <= 1'b0;
      if_resp_q       <= 1'b0;
      lsb_resp_q      <= 1'b0;
      instr_a_q       <= '0;
      lsb_addr_q      <= '0;
      lsb_din_q       <= '0;
      if_resp_data_q  <= '0;
      lsb_resp_data_q <= '0;
    end else if (rdy_in) begin
      if_resp_q  <= 1'b0;
      lsb_resp_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (lsb_req_ready) begin
            lsb_addr_q <= lsb_req_addr;
            lsb_din_q  <= lsb_req_data;
            last_lsb_q <= 1'b1;
            state_q    <= lsb_req_wr ? S_STORE : S_LOAD;
          end else if (if_req_ready) begin
            instr_a_q  <= if_req_addr;
            last_lsb_q <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (instr_done) begin
            state_q        <= S_IDLE;
            if_resp_data_q <= instr_d;
            if_resp_q      <= !(kill_q || rollback);
            kill_q         <= 1'b0;
          end else if (rollback) begin
            kill_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (lsb_done) begin
            state_q         <= S_IDLE;
            lsb_resp_data_q <= lsb_dout;
            lsb_resp_q      <= 1'b1;
          end
        end
        S_STORE: begin
          if (lsb_done) begin
            state_q         <= S_IDLE;
            lsb_resp_data_q <= '0;
            lsb_resp_q      <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: table of single transactions plus
// hand-written sequences for arbitration, rollback, rdy_in hold and reset.
module tb_mem_requester;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rollback;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready, if_resp_valid;
  logic [31:0] if_resp_data;
  logic        lsb_req_valid, lsb_req_wr;
  logic [31:0] lsb_req_addr, lsb_req_data;
  logic        lsb_req_ready, lsb_resp_valid;
  logic [31:0] lsb_resp_data;
  logic [1:0]  status_signal;
  logic [31:0] instr_a, instr_d, lsb_addr, lsb_din, lsb_dout;
  logic        instr_done, lsb_done;

  int checks = 0;
  int failures = 0;
  logic [31:0] if_q[$];
  logic [31:0] lsb_q[$];

  mem_requester dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback(rollback),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
    .if_resp_data(if_resp_data),
    .lsb_req_valid(lsb_req_valid), .lsb_req_wr(lsb_req_wr),
    .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data),
    .lsb_req_ready(lsb_req_ready), .lsb_resp_valid(lsb_resp_valid),
    .lsb_resp_data(lsb_resp_data),
    .status_signal(status_signal), .instr_a(instr_a), .instr_d(instr_d),
    .instr_done(instr_done), .lsb_addr(lsb_addr), .lsb_din(lsb_din),
    .lsb_dout(lsb_dout), .lsb_done(lsb_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response scoreboard: expectations are pushed when the done is driven.
  always @(negedge clk_in) begin
    if (if_resp_valid) begin
      if (if_q.size() == 0) chk("if_resp_unexpected", {31'b0, if_resp_valid}, 32'd0);
      else chk("if_resp_data", if_resp_data, if_q.pop_front());
    end
    if (lsb_resp_valid) begin
      if (lsb_q.size() == 0) chk("lsb_resp_unexpected", {31'b0, lsb_resp_valid}, 32'd0);
      else chk("lsb_resp_data", lsb_resp_data, lsb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_status"}, {30'b0, status_signal}, 32'd0);
    chk({tag, "_instr_a"}, instr_a, 32'd0);
    chk({tag, "_lsb_addr"}, lsb_addr, 32'd0);
    chk({tag, "_lsb_din"}, lsb_din, 32'd0);
    chk({tag, "_if_resp_data"}, if_resp_data, 32'd0);
    chk({tag, "_lsb_resp_data"}, lsb_resp_data, 32'd0);
    chk({tag, "_valids"}, {28'b0, if_resp_valid, lsb_resp_valid, if_req_ready, lsb_req_ready}, 32'd0);
  endtask

  // Waits (bounded) for a ready; returns 0 fetch, 1 lsb, -1 timeout.
  // Returns just after the accepting clock edge.
  task automatic wait_grant(output int who);
    who = -1;
    for (int n = 0; n < 30; n++) begin
      #1;
      chk("one_ready", {31'b0, if_req_ready & lsb_req_ready}, 32'd0);
      if (lsb_req_ready || if_req_ready) begin
        who = lsb_req_ready ? 1 : 0;
        tick();
        return;
      end
      @(negedge clk_in);
    end
    checks++;
    failures++;
    $display("FAIL grant_timeout actual=none required=ready");
  endtask

  // Checks the controller-side bus stays put for lat+1 cycles.
  task automatic hold_check(input logic [1:0] kind, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] exp_st, input int lat);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk_in); #1;
      chk("hold_status", {30'b0, status_signal}, {30'b0, exp_st});
      if (kind == K_FETCH) chk("hold_instr_a", instr_a, addr);
      else chk("hold_lsb_addr", lsb_addr, addr);
      if (kind == K_STORE) chk("hold_lsb_din", lsb_din, wdata);
      tick();
    end
  endtask

  task automatic finish_txn(input logic [1:0] kind, input logic [31:0] rdata);
    if (kind == K_FETCH) begin
      instr_d = rdata; instr_done = 1'b1; if_q.push_back(rdata);
    end else begin
      lsb_dout = rdata; lsb_done = 1'b1; lsb_q.push_back(kind == K_STORE ? 32'd0 : rdata);
    end
    tick();
    instr_done = 1'b0;
    lsb_done = 1'b0;
    @(negedge clk_in); #1;
    chk("post_done_status", {30'b0, status_signal}, 32'd0);
    chk("resp_seen", if_q.size() + lsb_q.size(), 32'd0);
  endtask

  task automatic run_txn(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input logic [1:0] exp_st);
    int who;
    if (kind == K_FETCH) begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end else begin
      lsb_req_valid = 1'b1; lsb_req_wr = (kind == K_STORE);
      lsb_req_addr = addr; lsb_req_data = wdata;
    end
    wait_grant(who);
    if_req_valid = 1'b0;
    lsb_req_valid = 1'b0;
    chk("grant_channel", who, (kind == K_FETCH) ? 32'd0 : 32'd1);
    if (who < 0) return;
    hold_check(kind, addr, wdata, exp_st, lat);
    finish_txn(kind, rdata);
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int who;
    vecs[0] = '{K_FETCH, 32'h0000_0100, 32'h0,         32'h00A0_0093, 2, 2'b11};
    vecs[1] = '{K_LOAD,  32'h0000_1000, 32'h0,         32'h1234_5678, 1, 2'b10};
    vecs[2] = '{K_STORE, 32'h0003_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 2'b01};
    vecs[3] = '{K_FETCH, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 0, 2'b11};
    vecs[4] = '{K_LOAD,  32'h0000_0004, 32'h0,         32'h0000_0000, 0, 2'b10};
    vecs[5] = '{K_STORE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_1111, 0, 2'b01};

    rst_in = 1'b1; rdy_in = 1'b1; rollback = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    lsb_req_valid = 1'b0; lsb_req_wr = 1'b0; lsb_req_addr = '0; lsb_req_data = '0;
    instr_d = '0; instr_done = 1'b0; lsb_dout = '0; lsb_done = 1'b0;
    tick(); tick();
    @(negedge clk_in); #1;
    chk_all_zero("reset");
    tick();
    rst_in = 1'b0;

    // Continuous contention straight after reset: load, fetch, load, fetch.
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0400;
    lsb_req_valid = 1'b1; lsb_req_wr = 1'b0; lsb_req_addr = 32'h0000_0800;
    for (int g = 0; g < 4; g++) begin
      wait_grant(who);
      chk("alt_grant", who, (g % 2 == 0) ? 32'd1 : 32'd0);
      if (who < 0) break;
      hold_check(who == 1 ? K_LOAD : K_FETCH, who == 1 ? 32'h0000_0800 : 32'h0000_0400,
                 32'h0, who == 1 ? 2'b10 : 2'b11, 0);
      finish_txn(who == 1 ? K_LOAD : K_FETCH, 32'hA000_0000 + g);
    end
    if_req_valid = 1'b0;
    lsb_req_valid = 1'b0;

    // Single-transaction table.
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat, vecs[i].exp_st);

    // Ready gating in IDLE: rdy_in low, then rollback high.
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0500; rdy_in = 1'b0;
    #1 chk("ready_rdy_low", {31'b0, if_req_ready}, 32'd0);
    rdy_in = 1'b1; rollback = 1'b1;
    #1 chk("ready_rollback", {31'b0, if_req_ready}, 32'd0);
    if_req_valid = 1'b0; rollback = 1'b0;
    tick();

    // Rollback mid-fetch: fetch result must be dropped.
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0140;
    wait_grant(who);
    if_req_valid = 1'b0;
    chk("rb_grant", who, 32'd0);
    hold_check(K_FETCH, 32'h0000_0140, 32'h0, 2'b11, 0);
    rollback = 1'b1; tick(); rollback = 1'b0; tick();
    instr_d = 32'h0BAD_0BAD; instr_done = 1'b1; tick(); instr_done = 1'b0;
    @(negedge clk_in); #1;
    chk("rb_status", {30'b0, status_signal}, 32'd0);
    chk("rb_no_resp", {31'b0, if_resp_valid}, 32'd0);
    tick(); tick();
    run_txn(K_FETCH, 32'h0000_0200, 32'h0, 32'h0130_0513, 1, 2'b11);

    // Rollback coinciding with instr_done.
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0300;
    wait_grant(who);
    if_req_valid = 1'b0;
    hold_check(K_FETCH, 32'h0000_0300, 32'h0, 2'b11, 0);
    instr_d = 32'h0DEA_D000; instr_done = 1'b1; rollback = 1'b1; tick();
    instr_done = 1'b0; rollback = 1'b0;
    @(negedge clk_in); #1;
    chk("rb_same_status", {30'b0, status_signal}, 32'd0);
    chk("rb_same_no_resp", {31'b0, if_resp_valid}, 32'd0);
    tick();

    // rdy_in low during LOAD with a toggling done.
    lsb_req_valid = 1'b1; lsb_req_wr = 1'b0; lsb_req_addr = 32'h0000_2000;
    wait_grant(who);
    lsb_req_valid = 1'b0;
    chk("rdy_grant", who, 32'd1);
    hold_check(K_LOAD, 32'h0000_2000, 32'h0, 2'b10, 0);
    rdy_in = 1'b0;
    lsb_dout = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      lsb_done = (i % 2 == 0);
      @(negedge clk_in); #1;
      chk("frz_status", {30'b0, status_signal}, 32'd2);
      chk("frz_lsb_addr", lsb_addr, 32'h0000_2000);
      chk("frz_no_resp", {31'b0, lsb_resp_valid}, 32'd0);
      tick();
    end
    rdy_in = 1'b1; lsb_done = 1'b0;
    @(negedge clk_in); #1;
    chk("thaw_status", {30'b0, status_signal}, 32'd2);
    tick();
    finish_txn(K_LOAD, 32'h55AA_55AA);

    // Reset in the middle of a store, with a coincident done.
    lsb_req_valid = 1'b1; lsb_req_wr = 1'b1;
    lsb_req_addr = 32'h0003_0100; lsb_req_data = 32'h1111_2222;
    wait_grant(who);
    lsb_req_valid = 1'b0;
    hold_check(K_STORE, 32'h0003_0100, 32'h1111_2222, 2'b01, 0);
    rst_in = 1'b1; lsb_done = 1'b1; lsb_dout = 32'h7777_7777;
    tick();
    lsb_done = 1'b0;
    @(negedge clk_in); #1;
    chk_all_zero("rst_store");
    tick();
    rst_in = 1'b0;
    repeat (3) tick();
    run_txn(K_STORE, 32'h0003_0200, 32'hCAFE_F00D, 32'h0, 1, 2'b01);

    chk("queues_empty", if_q.size() + lsb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
